pkt_arbiter: RTL
================

# pkt_arbiter

Round-robin packet arbiter that shares one head/tail/valid framed packet channel between NUM_REQ requesters. Grants are made only at packet boundaries and are held from the head beat to the tail beat, so packets never interleave. It sits in front of the packet framing state machine (IDLE/HEAD/DATA/TAIL) and feeds it a single well-formed packet stream with ready backpressure.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 16: payload width per beat.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_head  in  NUM_REQ  per-requester first-beat marker.
- req_tail  in  NUM_REQ  per-requester last-beat marker.
- req_data  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  beat accepted from requester i when req_valid[i] & req_ready[i].
- out_valid  out  1  output beat valid.
- out_head  out  1  output first-beat marker.
- out_tail  out  1  output last-beat marker.
- out_data  out  DATA_W  output payload.
- out_ready  in  1  downstream accepts beat when out_valid & out_ready.
- grant  out  NUM_REQ  registered one-hot owner; all-zero when idle.
- busy  out  1  high while a packet is locked.
- proto_err  out  1  sticky framing error flag (see Configuration).

## Operation
- Two one-hot states: ST_IDLE, ST_PKT. Registers: state, grant, rr_ptr (index of highest-priority requester).
- ST_IDLE: candidates = req_valid & req_head. Round-robin pick: first candidate searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. If any candidate: grant <= one-hot(winner), state <= ST_PKT. No candidate: stay. No beats transfer in ST_IDLE: out_valid=0, req_ready=0.
- ST_PKT with grant=g: out_valid/head/tail/data = req_valid[g]/req_head[g]/req_tail[g]/req_data slice g (combinational mux); req_ready[g]=out_ready; req_ready of all other requesters = 0.
- Transfer of a beat with out_tail=1 in ST_PKT: state <= ST_IDLE, grant <= 0, rr_ptr <= (g+1) mod NUM_REQ.
- Single-beat packet (head and tail on same beat) transfers and releases in one ST_PKT cycle.
- Requester valid without head in ST_IDLE: ignored, held off by req_ready=0.
- Non-granted requesters are stalled; their inputs must be held stable (upstream rule).
- busy = (state == ST_PKT).

## Timing
- Reset values: state=ST_IDLE, grant=0, rr_ptr=0, busy=0, out_valid=0, req_ready=0, proto_err=0.
- Arbitration latency: head presented in cycle N while idle -> grant and out_valid visible cycle N+1.
- Release: tail transferred at edge E -> ST_IDLE for one cycle after E -> next grant registered at E+1. Exactly one bubble cycle between packets.
- out_ready low: beat held; no state change; grant remains locked indefinitely.
- Reset mid-packet: next cycle ST_IDLE, grant=0, rr_ptr=0; partial packet is dropped; downstream sees no tail.
- rr_ptr wraps NUM_REQ-1 -> 0.

## Configuration
- PKT_ARB_PROTO_CHK_EN defined: proto_err sets (sticky until reset) on any of: in ST_PKT a transferred beat with out_head=1 other than the first beat of the packet; in ST_IDLE any req_valid[i] & ~req_head[i] for two or more consecutive cycles. Flag set the cycle after detection.
- Not defined: proto_err tied to 0, no checker logic.

## Structure
- Package pkt_arb_pkg: state encodings ST_IDLE=2'b01, ST_PKT=2'b10; NUM_REQ bounds constants; GNT_NONE all-zero constant.
- Sub-module pkt_rr_picker: combinational round-robin picker (inputs: candidates, rr_ptr; outputs: one-hot winner, any_valid). The output mux and FSM stay in pkt_arbiter.

## Test plan
- Single requester 2 sends head, 2 data, tail with out_ready=1 -> grant=4'b0100 one cycle after head, four beats out in order, grant=0 and rr_ptr=3 after tail.
- Requesters 0 and 1 both present head at rr_ptr=0 -> 0 wins, 1 stalled (req_ready[1]=0); after 0's tail plus one bubble, 1 is granted.
- All four requesters continuously requesting -> grant sequence 0,1,2,3,0 with exactly one idle cycle between packets.
- Granted packet with out_ready low for 5 cycles mid-packet -> out_valid held, same data, grant unchanged, no other requester served.
- Reset asserted during data beat of requester 3 -> next cycle grant=0, busy=0, out_valid=0, rr_ptr=0; subsequent head from 1 granted normally.
- With PKT_ARB_PROTO_CHK_EN: granted requester sends second head mid-packet -> proto_err=1 next cycle and stays 1 until reset; without macro proto_err stays 0.

Source files
------------

// File: rtl/pkt_arb_pkg.sv
// pkt_arb_pkg
//   Shared definitions for the round-robin packet arbiter: the one-hot FSM
//   state encoding, the supported requester-count bounds, the idle grant
//   value and a helper that sizes the round-robin pointer.
//   Optional checker macro used by pkt_arbiter: PKT_ARB_PROTO_CHK_EN.
package pkt_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_PKT  = 2'b10
  } arb_state_e;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  // Grant value while no packet is locked; sliced down to NUM_REQ bits.
  localparam logic [NUM_REQ_MAX-1:0] GNT_NONE = '0;

  // Width of a requester index / round-robin pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pkt_rr_picker.sv
// pkt_rr_picker
//   Combinational round-robin picker. Searches the candidate vector starting
//   at i_rr_ptr and wrapping modulo NUM_REQ; the first set candidate wins.
// Ports:
//   i_cand      [NUM_REQ]  requesters eligible this cycle
//   i_rr_ptr    [PTR_W]    index of the highest-priority requester
//   o_winner    [NUM_REQ]  one-hot winner, all-zero when nothing eligible
//   o_any_valid            at least one candidate present
module pkt_rr_picker
  import pkt_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_cand,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_winner,
  output logic               o_any_valid
);

  // Walk the requesters in priority order beginning at the pointer. Once a
  // winner is found, later positions are ignored so the result stays one-hot.
  always_comb begin
    int w_idx;
    w_idx       = 0;
    o_winner    = '0;
    o_any_valid = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx = int'(i_rr_ptr) + off;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      if (!o_any_valid && i_cand[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        o_any_valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_arbiter.sv
// pkt_arbiter
//   Round-robin packet arbiter sharing one head/tail/valid framed channel
//   between NUM_REQ requesters. A requester is granted only when it presents
//   a head beat while the arbiter is idle, and keeps the grant until its tail
//   beat is accepted downstream, so packets never interleave. One idle bubble
//   cycle separates consecutive packets.
// Ports:
//   i_clk, i_reset                       clock, synchronous active-high reset
//   i_req_valid/head/tail [NUM_REQ]      per-requester beat framing
//   i_req_data [NUM_REQ*DATA_W]          requester i in [i*DATA_W +: DATA_W]
//   o_req_ready [NUM_REQ]                beat accept, only for the owner
//   o_out_valid/head/tail, o_out_data    muxed output beat
//   i_out_ready                          downstream backpressure
//   o_grant [NUM_REQ]                    registered one-hot owner, 0 if idle
//   o_busy                               a packet is locked
//   o_proto_err                          sticky framing error flag
// Configuration:
//   PKT_ARB_PROTO_CHK_EN  when defined, builds the framing checker that
//   drives o_proto_err; otherwise o_proto_err is tied low.
module pkt_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_head,
  input  logic [NUM_REQ-1:0]        i_req_tail,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_out_valid,
  output logic                      o_out_head,
  output logic                      o_out_tail,
  output logic [DATA_W-1:0]         o_out_data,
  input  logic                      i_out_ready,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_busy,
  output logic                      o_proto_err
);

  localparam int               PTR_W    = ptr_width(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  arb_state_e         r_state,   w_state_nxt;
  logic [NUM_REQ-1:0] r_grant,   w_grant_nxt;
  logic [PTR_W-1:0]   r_gnt_idx, w_gnt_idx_nxt;
  logic [PTR_W-1:0]   r_rr_ptr,  w_rr_ptr_nxt;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_winner;
  logic [PTR_W-1:0]   w_win_idx;
  logic               w_any;
  logic               w_xfer;

  // Only requesters offering the first beat of a packet may win.
  assign w_cand = i_req_valid & i_req_head;

  pkt_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_cand      (w_cand),
    .i_rr_ptr    (r_rr_ptr),
    .o_winner    (w_winner),
    .o_any_valid (w_any)
  );

  // Binary index of the one-hot winner; kept alongside the grant so the
  // output mux and pointer update do not need to re-encode every cycle.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner[i]) begin
        w_win_idx = PTR_W'(i);
      end
    end
  end

  // A beat moves only while locked, when the owner is valid and downstream
  // is ready.
  assign w_xfer = (r_state == ST_PKT) && o_out_valid && i_out_ready;

  // Next-state logic. Idle arbitrates among head beats; a locked packet is
  // released when its tail beat transfers, and the pointer moves one past
  // the released owner so it gets lowest priority next time.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_gnt_idx_nxt = r_gnt_idx;
    w_rr_ptr_nxt  = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt   = ST_PKT;
          w_grant_nxt   = w_winner;
          w_gnt_idx_nxt = w_win_idx;
        end
      end
      ST_PKT: begin
        if (w_xfer && o_out_tail) begin
          w_state_nxt  = ST_IDLE;
          w_grant_nxt  = GNT_NONE[NUM_REQ-1:0];
          w_rr_ptr_nxt = (r_gnt_idx == LAST_IDX) ? '0 : r_gnt_idx + PTR_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = GNT_NONE[NUM_REQ-1:0];
      end
    endcase
  end

  // State, grant and pointer registers. Reset drops any partial packet.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= GNT_NONE[NUM_REQ-1:0];
      r_gnt_idx <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
    end
  end

  // Output mux: while locked, the owner's framing and data pass straight
  // through and only the owner sees downstream ready. Idle moves nothing.
  always_comb begin
    o_out_valid = 1'b0;
    o_out_head  = 1'b0;
    o_out_tail  = 1'b0;
    o_out_data  = '0;
    o_req_ready = '0;
    if (r_state == ST_PKT) begin
      o_out_valid            = i_req_valid[r_gnt_idx];
      o_out_head             = i_req_head[r_gnt_idx];
      o_out_tail             = i_req_tail[r_gnt_idx];
      o_out_data             = i_req_data[int'(r_gnt_idx)*DATA_W +: DATA_W];
      o_req_ready[r_gnt_idx] = i_out_ready;
    end
  end

  assign o_grant = r_grant;
  assign o_busy  = (r_state == ST_PKT);

`ifdef PKT_ARB_PROTO_CHK_EN
  logic               r_first_beat;
  logic               r_proto_err;
  logic [NUM_REQ-1:0] r_nohead_prev;
  logic [NUM_REQ-1:0] w_nohead;
  logic               w_err_dup_head;
  logic               w_err_nohead;

  // Body beats offered while idle; two in a row from the same requester
  // means it lost track of its framing.
  assign w_nohead       = (r_state == ST_IDLE) ? (i_req_valid & ~i_req_head) : '0;
  assign w_err_nohead   = |(w_nohead & r_nohead_prev);
  assign w_err_dup_head = w_xfer && o_out_head && !r_first_beat;

  // Checker state. r_first_beat is re-armed during every idle cycle so it is
  // set on entry to a packet and clears once the first beat has moved.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_first_beat  <= 1'b1;
      r_nohead_prev <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      r_nohead_prev <= w_nohead;
      if (r_state == ST_IDLE) begin
        r_first_beat <= 1'b1;
      end else if (w_xfer) begin
        r_first_beat <= 1'b0;
      end
      if (w_err_dup_head || w_err_nohead) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign o_proto_err = r_proto_err;
`else
  assign o_proto_err = 1'b0;
`endif

endmodule
